// File: rtl/booth_multiplier.sv
// Sequential 32x32 signed multiplier, radix-4 Booth recoding.
//
// Retires two multiplier bits per clock; a product takes 16 iterations after
// the start edge. The per-iteration datapath is a 34-bit ripple-carry
// adder/subtractor built from full-adder gate equations, followed by a
// 2-bit arithmetic right shift of {A, Q, q_-1}.
//
// Ports:
//   clk           system clock, rising edge
//   reset_n       asynchronous active-low reset
//   op_start      start request, honoured only in IDLE
//   op_clear      synchronous abort/acknowledge, returns to IDLE from any state
//   multiplicand  signed operand M, captured on the start edge
//   multiplier    signed operand Q, captured on the start edge
//   op_done       high while the product is available
//   result        signed 64-bit product, zero whenever op_done is low

module booth_multiplier (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        op_start,
    input  logic        op_clear,
    input  logic [31:0] multiplicand,
    input  logic [31:0] multiplier,
    output logic        op_done,
    output logic [63:0] result
);

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StDone
    } state_e;

    state_e      state_q;
    logic [33:0] m_q;       // multiplicand, sign-extended to 34 bits
    logic [33:0] a_q;       // accumulator
    logic [31:0] q_q;       // multiplier, shifted right as bits are retired
    logic        qm1_q;     // guard bit q_-1
    logic [4:0]  count_q;
    logic [63:0] result_q;
    logic        done_q;

    // ------------------------------------------------------------------
    // Booth decode of {q1, q0, q_-1}
    // ------------------------------------------------------------------
    logic [2:0] booth_triple;
    logic       add_zero;
    logic       add_double;
    logic       add_neg;

    always_comb begin
        booth_triple = {q_q[1:0], qm1_q};
        add_zero     = 1'b0;
        add_double   = 1'b0;
        add_neg      = 1'b0;
        unique case (booth_triple)
            3'b000, 3'b111: add_zero = 1'b1;
            3'b001, 3'b010: add_zero = 1'b0;
            3'b011:         add_double = 1'b1;
            3'b100: begin
                add_double = 1'b1;
                add_neg    = 1'b1;
            end
            3'b101, 3'b110: add_neg = 1'b1;
            default:        add_zero = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Operand select: 0, M or 2M, inverted for subtraction. The +1 of the
    // two's complement enters as the adder's carry-in.
    // ------------------------------------------------------------------
    logic [33:0] mag_op;
    logic [33:0] add_op;

    always_comb begin
        if (add_zero) begin
            mag_op = 34'd0;
        end else if (add_double) begin
            mag_op = {m_q[32:0], 1'b0};
        end else begin
            mag_op = m_q;
        end
        add_op = mag_op ^ {34{add_neg}};
    end

    // ------------------------------------------------------------------
    // 34-bit ripple-carry adder from full-adder gate equations.
    // Carry out of bit 33 is discarded: the sum is modulo 2^34 and cannot
    // overflow for 32-bit signed operands.
    // ------------------------------------------------------------------
    logic [33:0] sum;
    logic        carry;

    always_comb begin
        sum   = 34'd0;
        carry = add_neg;
        for (int i = 0; i < 34; i++) begin
            sum[i] = a_q[i] ^ add_op[i] ^ carry;
            carry  = (a_q[i] & add_op[i]) | (carry & (a_q[i] ^ add_op[i]));
        end
    end

    // ------------------------------------------------------------------
    // Arithmetic shift right by 2 of {sum, Q, q_-1}: the two low sum bits
    // move into the top of Q, and Q[1] becomes the next guard bit.
    // ------------------------------------------------------------------
    logic [33:0] a_shift;
    logic [31:0] q_shift;
    logic        qm1_shift;

    always_comb begin
        a_shift   = {{2{sum[33]}}, sum[33:2]};
        q_shift   = {sum[1:0], q_q[31:2]};
        qm1_shift = q_q[1];
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            m_q      <= 34'd0;
            a_q      <= 34'd0;
            q_q      <= 32'd0;
            qm1_q    <= 1'b0;
            count_q  <= 5'd0;
            result_q <= 64'd0;
            done_q   <= 1'b0;
        end else if (op_clear) begin
            // Abort/acknowledge wins over everything, including the final
            // iteration edge, so DONE is never entered on that edge.
            state_q  <= StIdle;
            a_q      <= 34'd0;
            count_q  <= 5'd0;
            result_q <= 64'd0;
            done_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (op_start) begin
                        m_q     <= {{2{multiplicand[31]}}, multiplicand};
                        a_q     <= 34'd0;
                        q_q     <= multiplier;
                        qm1_q   <= 1'b0;
                        count_q <= 5'd0;
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    a_q     <= a_shift;
                    q_q     <= q_shift;
                    qm1_q   <= qm1_shift;
                    count_q <= count_q + 5'd1;
                    if (count_q == 5'd15) begin
                        // Product fits in 64 bits, so the top two bits of A
                        // are pure sign replication and can be dropped.
                        state_q  <= StDone;
                        done_q   <= 1'b1;
                        result_q <= {a_shift[31:0], q_shift};
                    end
                end
                StDone: begin
                    state_q <= StDone;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign op_done = done_q;
    assign result  = result_q;

endmodule

// File: tb/tb_booth_multiplier.sv
module tb_booth_multiplier;

    logic        clk;
    logic        reset_n;
    logic        op_start;
    logic        op_clear;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        op_done;
    logic [63:0] result;

    booth_multiplier dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .op_start     (op_start),
        .op_clear     (op_clear),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .op_done      (op_done),
        .result       (result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard queues, filled by the stimulus, drained by the monitor.
    logic [63:0] exp_q[$];
    int          start_q[$];
    string       name_q[$];

    // Reference model: plain signed 64-bit arithmetic.
    function automatic logic [63:0] ref_mul(input logic [31:0] m, input logic [31:0] q);
        longint pm;
        longint pq;
        pm = longint'($signed(m));
        pq = longint'($signed(q));
        return 64'(pm * pq);
    endfunction

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    logic        mon_done_prev = 1'b0;
    logic [63:0] mon_held      = 64'd0;
    logic [63:0] mon_exp;
    int          mon_start;
    string       mon_name;

    always @(negedge clk) begin
        if (!reset_n) begin
            mon_done_prev = 1'b0;
        end else begin
            if (op_done && !mon_done_prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got op_done=1 result=%h required op_done=0",
                             result);
                end else begin
                    mon_exp   = exp_q.pop_front();
                    mon_start = start_q.pop_front();
                    mon_name  = name_q.pop_front();
                    chk64({mon_name, "_result"}, result, mon_exp);
                    chk_int({mon_name, "_latency"}, cyc - mon_start, 16);
                end
                mon_held = result;
            end else if (op_done) begin
                chk64("hold_result", result, mon_held);
            end else begin
                chk64("not_done_result_zero", result, 64'd0);
            end
            mon_done_prev = op_done;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic do_start(input logic [31:0] m, input logic [31:0] q,
                            input logic [63:0] expv, input bit track, input string name);
        @(negedge clk);
        multiplicand = m;
        multiplier   = q;
        op_start     = 1'b1;
        @(posedge clk);
        #1;
        op_start     = 1'b0;
        multiplicand = $urandom;
        multiplier   = $urandom;
        if (track) begin
            exp_q.push_back(expv);
            start_q.push_back(cyc);
            name_q.push_back(name);
        end
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no op_done in 40 cycles required op_done", name);
            exp_q.delete();
            start_q.delete();
            name_q.delete();
        end
    endtask

    task automatic do_clear(input string name);
        @(negedge clk);
        op_clear = 1'b1;
        @(posedge clk);
        #1;
        op_clear = 1'b0;
        chk64({name, "_clear_done"}, 64'(op_done), 64'd0);
        chk64({name, "_clear_result"}, result, 64'd0);
    endtask

    logic [31:0] corner_m[5] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF,
                                 32'h8000_0000, 32'h0000_0000};
    logic [31:0] corner_q[5] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF,
                                 32'h7FFF_FFFF, 32'h1234_5678};
    logic [63:0] corner_p[5] = '{64'h4000_0000_0000_0000, 64'h3FFF_FFFF_0000_0001,
                                 64'h0000_0000_0000_0001, 64'hC000_0000_8000_0000,
                                 64'h0000_0000_0000_0000};
    logic [31:0] pick_vals[4] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};

    function automatic logic [31:0] pick_operand();
        if ($urandom_range(0, 3) == 0) return pick_vals[$urandom_range(0, 3)];
        return $urandom;
    endfunction

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        logic [31:0] rm;
        logic [31:0] rq;

        // Reset with random inputs, checked before the first clock edge.
        reset_n      = 1'b0;
        op_start     = 1'($urandom);
        op_clear     = 1'($urandom);
        multiplicand = $urandom;
        multiplier   = $urandom;
        #2;
        chk64("reset_done", 64'(op_done), 64'd0);
        chk64("reset_result", result, 64'd0);
        repeat (3) begin
            @(negedge clk);
            op_start     = 1'($urandom);
            op_clear     = 1'($urandom);
            multiplicand = $urandom;
            multiplier   = $urandom;
        end
        @(negedge clk);
        op_start = 1'b0;
        op_clear = 1'b0;
        reset_n  = 1'b1;
        repeat (20) begin
            @(negedge clk);
            #1;
            multiplicand = $urandom;
            multiplier   = $urandom;
        end

        // Basic product, latency, hold, clear.
        do_start(32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 1'b1, "basic");
        wait_done("basic");
        repeat (10) @(negedge clk);
        #1;
        chk64("basic_hold_done", 64'(op_done), 64'd1);
        chk64("basic_hold_result", result, 64'hFFFF_FFFF_FFFF_FFEB);
        do_clear("basic");

        // Corner operands.
        for (int i = 0; i < 5; i++) begin
            do_start(corner_m[i], corner_q[i], corner_p[i], 1'b1, $sformatf("corner%0d", i));
            wait_done("corner");
            do_clear("corner");
        end

        // Re-pulsed start and operand churn during EXEC are ignored.
        do_start(32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 1'b1, "restart_ignored");
        repeat (4) @(posedge clk);
        @(negedge clk);
        op_start     = 1'b1;
        multiplicand = 32'd3;
        multiplier   = 32'd3;
        @(posedge clk);
        #1;
        op_start = 1'b0;
        repeat (5) begin
            @(negedge clk);
            multiplicand = $urandom;
            multiplier   = $urandom;
        end
        wait_done("restart_ignored");
        do_clear("restart_ignored");

        // Abort at t+8, restart 5 x 6 at t+9.
        do_start($urandom | 32'h1, $urandom | 32'h1, 64'd0, 1'b0, "abort");
        repeat (7) @(posedge clk);
        do_clear("abort");
        do_start(32'd5, 32'd6, 64'd30, 1'b1, "after_abort");
        wait_done("after_abort");
        do_clear("after_abort");

        // Clear on the 16th iteration edge: DONE never entered.
        do_start(32'd9, 32'd9, 64'd0, 1'b0, "clear16");
        repeat (15) @(posedge clk);
        do_clear("clear16");
        repeat (20) @(negedge clk);

        // Start and clear together in IDLE: no start.
        @(negedge clk);
        op_start     = 1'b1;
        op_clear     = 1'b1;
        multiplicand = 32'd11;
        multiplier   = 32'd13;
        @(posedge clk);
        #1;
        op_start = 1'b0;
        op_clear = 1'b0;
        repeat (20) @(negedge clk);

        // Asynchronous reset while in DONE.
        do_start(32'h0000_1234, 32'h0000_5678, 64'h0000_0000_0626_0060, 1'b1, "pre_reset");
        wait_done("pre_reset");
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk64("reset_in_done_done", 64'(op_done), 64'd0);
        chk64("reset_in_done_result", result, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Asynchronous reset mid-EXEC, then a fresh product.
        do_start(32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 1'b1, "mid_exec");
        repeat (9) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk64("reset_mid_exec_done", 64'(op_done), 64'd0);
        chk64("reset_mid_exec_result", result, 64'd0);
        exp_q.delete();
        start_q.delete();
        name_q.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        do_start(32'hFFFF_FFFE, 32'h0000_0010, 64'hFFFF_FFFF_FFFF_FFE0, 1'b1, "after_reset");
        wait_done("after_reset");
        do_clear("after_reset");

        // Randomized products against the reference model.
        for (int i = 0; i < 40; i++) begin
            rm = pick_operand();
            rq = pick_operand();
            do_start(rm, rq, ref_mul(rm, rq), 1'b1, $sformatf("rand%0d", i));
            wait_done("rand");
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_clear("rand");
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
